// File: rtl/verlet_node_scheduler.sv
// verlet_node_scheduler
// Runs one cloth/verlet frame on request: a verlet-update sweep over all NODES,
// then CONSTRAINT_ITERS constraint-fix sweeps. Exactly one node is enabled at a
// time and the scheduler advances only on that node's done bit.
// Optional watchdog: define SCHED_TIMEOUT_EN to force an advance after TIMEOUT
// silent cycles and raise the sticky timeout_err flag.
// Ports:
//   clk, reset     - clock and synchronous active-high reset
//   start          - request one frame (honoured only in IDLE)
//   node_done      - per-node completion, only the enabled node's bit counts
//   verlet_en      - one-hot verlet-step enable
//   constraint_en  - one-hot constraint-fix enable
//   active_node    - index of the enabled node, 0 when idle
//   busy           - frame in progress (through the DONE cycle)
//   frame_done     - one-cycle pulse in DONE
//   step_count     - completed frame counter, wraps
//   timeout_err    - sticky watchdog flag (SCHED_TIMEOUT_EN only)
module verlet_node_scheduler #(
    parameter int unsigned NODES            = 5,
    parameter int unsigned CONSTRAINT_ITERS = 2,
    parameter int unsigned STEP_W           = 16,
    parameter int unsigned TIMEOUT          = 64
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic [NODES-1:0]                              node_done,
    output logic [NODES-1:0]                              verlet_en,
    output logic [NODES-1:0]                              constraint_en,
    output logic [((NODES > 1) ? $clog2(NODES) : 1)-1:0]  active_node,
    output logic                                          busy,
    output logic                                          frame_done,
`ifdef SCHED_TIMEOUT_EN
    output logic [STEP_W-1:0]                             step_count,
    output logic                                          timeout_err
`else
    output logic [STEP_W-1:0]                             step_count
`endif
);

    localparam int unsigned AW = (NODES > 1) ? $clog2(NODES) : 1;
    localparam int unsigned IW = (CONSTRAINT_ITERS > 1) ? $clog2(CONSTRAINT_ITERS + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_VERLET     = 2'd1,
        S_CONSTRAINT = 2'd2,
        S_DONE       = 2'd3
    } state_t;

    state_t        state;
    logic [IW-1:0] iter;

    logic hit_c;
    logic last_c;
    logic working_c;
    logic advance_c;

    // The enables are one-hot, so masking with them selects the active node's done bit.
    assign hit_c     = |(node_done & (verlet_en | constraint_en));
    assign last_c    = (active_node == AW'(NODES - 1));
    assign working_c = (state == S_VERLET) || (state == S_CONSTRAINT);

`ifdef SCHED_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [TW-1:0] wait_cnt;
    logic          expire_c;

    assign expire_c  = (wait_cnt == TW'(TIMEOUT - 1));
    assign advance_c = hit_c || expire_c;

    // Watchdog: counts cycles the current enable has been held without a done.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (working_c && !advance_c) begin
                wait_cnt <= wait_cnt + TW'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (working_c && expire_c && !hit_c) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign advance_c = hit_c;
`endif

    // Frame sequencer: IDLE -> VERLET -> CONSTRAINT -> DONE -> IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            iter          <= '0;
            verlet_en     <= '0;
            constraint_en <= '0;
            active_node   <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            step_count    <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_VERLET;
                        verlet_en   <= NODES'(1);
                        active_node <= '0;
                        iter        <= '0;
                        busy        <= 1'b1;
                    end
                end
                S_VERLET: begin
                    if (advance_c) begin
                        if (!last_c) begin
                            verlet_en   <= verlet_en << 1;
                            active_node <= active_node + AW'(1);
                        end else begin
                            verlet_en   <= '0;
                            active_node <= '0;
                            if (CONSTRAINT_ITERS == 0) begin
                                state      <= S_DONE;
                                frame_done <= 1'b1;
                                step_count <= step_count + STEP_W'(1);
                            end else begin
                                state         <= S_CONSTRAINT;
                                constraint_en <= NODES'(1);
                                iter          <= '0;
                            end
                        end
                    end
                end
                S_CONSTRAINT: begin
                    if (advance_c) begin
                        if (!last_c) begin
                            constraint_en <= constraint_en << 1;
                            active_node   <= active_node + AW'(1);
                        end else if (iter != IW'(CONSTRAINT_ITERS - 1)) begin
                            // Another constraint sweep: restart at node 0 without a gap.
                            iter          <= iter + IW'(1);
                            constraint_en <= NODES'(1);
                            active_node   <= '0;
                        end else begin
                            state         <= S_DONE;
                            constraint_en <= '0;
                            active_node   <= '0;
                            frame_done    <= 1'b1;
                            step_count    <= step_count + STEP_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
